// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if
//   Command/status bundle between a key-sequence source and the keypad
//   emulator.
//   cmd_valid  request to press one key
//   cmd_key    hex code of the key to press (0x0-0xF)
//   cmd_ready  emulator is idle and will accept a request this cycle
//   pressed    key contact phase in progress (bounce window included)
//   done       one-cycle pulse in the last cycle of the release gap
//   Modports: master drives commands, slave is the emulator.

interface keypad_emulator_if;
    logic       cmd_valid;
    logic [3:0] cmd_key;
    logic       cmd_ready;
    logic       pressed;
    logic       done;

    modport master (
        output cmd_valid,
        output cmd_key,
        input  cmd_ready,
        input  pressed,
        input  done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_key,
        output cmd_ready,
        output pressed,
        output done
    );
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Passive end of a 4x4 column-scan keypad. Watches the active-low column
//   lines from a scanner and pulls the matching active-low row line while a
//   commanded key is held, exactly like a physical key switch would.
//
//   Ports
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     cmd    keypad_emulator_if.slave (cmd_valid/cmd_key/cmd_ready/pressed/done)
//     Col    column lines from scanner, active low, Col[3] = C1 .. Col[0] = C4
//     Row    row lines to scanner, active low, registered, Row[3] = R1 .. Row[0] = R4
//
//   Build option
//     KEYPAD_EMU_BOUNCE_EN : when defined, each press starts with a contact
//     bounce window of BOUNCE_CYCLES cycles in which the contact toggles every
//     BOUNCE_PERIOD cycles. When undefined the bounce state and its counters
//     do not exist and the BOUNCE_* parameters have no effect.

module keypad_emulator #(
    parameter int unsigned HOLD_CYCLES   = 10_000_000,
    parameter int unsigned GAP_CYCLES    = 5_000_000,
    parameter int unsigned BOUNCE_CYCLES = 200_000,
    parameter int unsigned BOUNCE_PERIOD = 10_000
) (
    input  logic               clk,
    input  logic               rst_n,
    keypad_emulator_if.slave   cmd,
    input  logic [3:0]         Col,
    output logic [3:0]         Row
);

    // Counters count down from (parameter - 1); a zero parameter loads 0,
    // which still yields a one-cycle phase.
    localparam logic [31:0] HOLD_LOAD = (HOLD_CYCLES == 0) ? 32'd0 : HOLD_CYCLES - 32'd1;
    localparam logic [31:0] GAP_LOAD  = (GAP_CYCLES  == 0) ? 32'd0 : GAP_CYCLES  - 32'd1;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [31:0] BOUNCE_LOAD = (BOUNCE_CYCLES == 0) ? 32'd0 : BOUNCE_CYCLES - 32'd1;
    localparam logic [31:0] PERIOD_LOAD = (BOUNCE_PERIOD == 0) ? 32'd0 : BOUNCE_PERIOD - 32'd1;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
`ifdef KEYPAD_EMU_BOUNCE_EN
        BOUNCE = 2'd1,
`endif
        PRESS  = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q,   cnt_d;
    logic [3:0]  key_q,   key_d;
    logic [3:0]  row_q,   row_d;
`ifdef KEYPAD_EMU_BOUNCE_EN
    logic [31:0] period_q, period_d;
    logic        closed_q, closed_d;
`endif

    logic        contact_d;
    logic [1:0]  colBit;
    logic [1:0]  rowBit;

    // Key map: translate the key that will be held after this edge into the
    // Col bit it listens on and the Row bit it pulls low.
    always_comb begin
        colBit = 2'd3;
        rowBit = 2'd3;
        case (key_d)
            4'h1: begin colBit = 2'd3; rowBit = 2'd3; end
            4'h4: begin colBit = 2'd3; rowBit = 2'd2; end
            4'h7: begin colBit = 2'd3; rowBit = 2'd1; end
            4'h0: begin colBit = 2'd3; rowBit = 2'd0; end
            4'h2: begin colBit = 2'd2; rowBit = 2'd3; end
            4'h5: begin colBit = 2'd2; rowBit = 2'd2; end
            4'h8: begin colBit = 2'd2; rowBit = 2'd1; end
            4'hF: begin colBit = 2'd2; rowBit = 2'd0; end
            4'h3: begin colBit = 2'd1; rowBit = 2'd3; end
            4'h6: begin colBit = 2'd1; rowBit = 2'd2; end
            4'h9: begin colBit = 2'd1; rowBit = 2'd1; end
            4'hE: begin colBit = 2'd1; rowBit = 2'd0; end
            4'hA: begin colBit = 2'd0; rowBit = 2'd3; end
            4'hB: begin colBit = 2'd0; rowBit = 2'd2; end
            4'hC: begin colBit = 2'd0; rowBit = 2'd1; end
            4'hD: begin colBit = 2'd0; rowBit = 2'd0; end
            default: begin colBit = 2'd3; rowBit = 2'd3; end
        endcase
    end

    // Phase sequencing. Each phase loads its countdown on entry and leaves
    // when the count reaches zero. The row image is computed from the state
    // that will be in effect after the edge, so the contact is visible on Row
    // from the first cycle of the press and is released as soon as the gap
    // begins.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
`ifdef KEYPAD_EMU_BOUNCE_EN
        period_d  = period_q;
        closed_d  = closed_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    key_d    = cmd.cmd_key;
`ifdef KEYPAD_EMU_BOUNCE_EN
                    state_d  = BOUNCE;
                    cnt_d    = BOUNCE_LOAD;
                    period_d = PERIOD_LOAD;
                    closed_d = 1'b1;
`else
                    state_d  = PRESS;
                    cnt_d    = HOLD_LOAD;
`endif
                end
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            BOUNCE: begin
                if (cnt_q == 32'd0) begin
                    state_d = PRESS;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                    // contact flips each time the period counter runs out
                    if (period_q == 32'd0) begin
                        period_d = PERIOD_LOAD;
                        closed_d = ~closed_q;
                    end else begin
                        period_d = period_q - 32'd1;
                    end
                end
            end
`endif
            PRESS: begin
                if (cnt_q == 32'd0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            GAP: begin
                if (cnt_q == 32'd0) begin
                    state_d = IDLE;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 32'd0;
            end
        endcase

`ifdef KEYPAD_EMU_BOUNCE_EN
        contact_d = (state_d == PRESS) || ((state_d == BOUNCE) && closed_d);
`else
        contact_d = (state_d == PRESS);
`endif

        // A closed contact only shorts the row when the scanner drives this
        // key's column low; other low columns do not matter.
        row_d = 4'b1111;
        if (contact_d && !Col[colBit]) begin
            row_d[rowBit] = 1'b0;
        end
    end

    // State, counters, latched key and the registered row image. Reset
    // releases the row immediately and returns to IDLE without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 32'd0;
            key_q    <= 4'h0;
            row_q    <= 4'b1111;
`ifdef KEYPAD_EMU_BOUNCE_EN
            period_q <= 32'd0;
            closed_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            row_q    <= row_d;
`ifdef KEYPAD_EMU_BOUNCE_EN
            period_q <= period_d;
            closed_q <= closed_d;
`endif
        end
    end

    // Status outputs are plain decodes of registered state; done marks the
    // final gap cycle so cmd_ready rises right after it.
    assign Row           = row_q;
    assign cmd.cmd_ready = (state_q == IDLE);
`ifdef KEYPAD_EMU_BOUNCE_EN
    assign cmd.pressed   = (state_q == PRESS) || (state_q == BOUNCE);
`else
    assign cmd.pressed   = (state_q == PRESS);
`endif
    assign cmd.done      = (state_q == GAP) && (cnt_q == 32'd0);

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator
//   Drives scripted and random key commands into keypad_emulator, scans the
//   columns like a keypad scanner would, and compares Row/cmd_ready/pressed/
//   done every cycle against a timeline model of a press.
//   Honours KEYPAD_EMU_BOUNCE_EN the same way the design does.

module tb_keypad_emulator;

    localparam int unsigned HOLD = 100;
    localparam int unsigned GAPC = 50;
    localparam int unsigned BCYC = 40;
    localparam int unsigned BPER = 10;

    localparam int H = (HOLD == 0) ? 1 : int'(HOLD);
    localparam int G = (GAPC == 0) ? 1 : int'(GAPC);
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int B = (BCYC == 0) ? 1 : int'(BCYC);
    localparam int P = (BPER == 0) ? 1 : int'(BPER);
`else
    localparam int B = 0;
    localparam int P = 1;
`endif
    localparam int BOUND = B + H + G + 20;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] Col;
    logic [3:0] Row;

    keypad_emulator_if cmdIf ();

    keypad_emulator #(
        .HOLD_CYCLES   (HOLD),
        .GAP_CYCLES    (GAPC),
        .BOUNCE_CYCLES (BCYC),
        .BOUNCE_PERIOD (BPER)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (cmdIf),
        .Col   (Col),
        .Row   (Row)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Physical keypad layout: layout[r][c], r = R1..R4, c = C1..C4.
    logic [3:0] layout [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void keyPos(input logic [3:0] key, output int r, output int c);
        r = 0;
        c = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (layout[i][j] == key) begin
                    r = i;
                    c = j;
                end
    endfunction

    // Reference model: a press is a timeline indexed by the number of clock
    // edges since the accept. Ages 1..B are bounce, B+1..B+H held, the next
    // G ages are the release gap with done on the last one.
    bit         busy = 0;
    int         age  = 0;
    logic [3:0] mKey = 4'h0;
    logic [3:0] expRow     = 4'hF;
    logic       expReady   = 1'b1;
    logic       expPressed = 1'b0;
    logic       expDone    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit contact;
        int r, c;
        if (!rst_n) begin
            busy = 0; age = 0;
            expRow = 4'hF; expReady = 1'b1; expPressed = 1'b0; expDone = 1'b0;
        end else begin
            if (busy && age == B + H + G) busy = 0;
            else if (busy) age++;
            else if (cmdIf.cmd_valid) begin
                busy = 1; age = 1; mKey = cmdIf.cmd_key;
            end
            expReady   = !busy;
            expPressed = busy && (age <= B + H);
            expDone    = busy && (age == B + H + G);
            if (!busy) contact = 0;
            else if (age <= B) contact = (((age - 1) / P) % 2) == 0;
            else contact = (age <= B + H);
            expRow = 4'hF;
            if (contact) begin
                keyPos(mKey, r, c);
                if (!Col[3 - c]) expRow[3 - r] = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("row",     {28'd0, Row},             {28'd0, expRow});
            checkOutput("ready",   {31'd0, cmdIf.cmd_ready}, {31'd0, expReady});
            checkOutput("pressed", {31'd0, cmdIf.pressed},   {31'd0, expPressed});
            checkOutput("done",    {31'd0, cmdIf.done},      {31'd0, expDone});
        end
    end

    // Wait for cmd_ready, request one key, and return just after the accept
    // edge so the caller's next negedge is the first press cycle.
    task automatic applyStimulus(input logic [3:0] key);
        int n = 0;
        @(negedge clk);
        while (!cmdIf.cmd_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!cmdIf.cmd_ready) checkOutput("readyTimeout", 32'd0, 32'd1);
        cmdIf.cmd_valid = 1'b1;
        cmdIf.cmd_key   = key;
        @(posedge clk);
        #2;
        cmdIf.cmd_valid = 1'b0;
        cmdIf.cmd_key   = 4'($urandom);
    endtask

    task automatic waitDone(input string name);
        bit seen = 0;
        for (int n = 0; n < BOUND && !seen; n++) begin
            @(negedge clk);
            if (cmdIf.done) seen = 1;
        end
        if (!seen) checkOutput(name, 32'd0, 32'd1);
    endtask

    initial begin
        logic [3:0] colPat [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        logic [3:0] prevX;
        logic [3:0] decoded;
        bit         found;
        int         pc, gc, doneCnt;

        cmdIf.cmd_valid = 1'b0;
        cmdIf.cmd_key   = 4'h0;
        Col             = 4'hF;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstRow",     {28'd0, Row},             32'hF);
        checkOutput("rstReady",   {31'd0, cmdIf.cmd_ready}, 32'd1);
        checkOutput("rstPressed", {31'd0, cmdIf.pressed},   32'd0);
        checkOutput("rstDone",    {31'd0, cmdIf.done},      32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        checkEn = 1;

        // idle scan: no command, every column low in turn
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) Col = colPat[i];
            @(negedge clk);
            checkOutput("idleRow",   {28'd0, Row},             32'hF);
            checkOutput("idleReady", {31'd0, cmdIf.cmd_ready}, 32'd1);
        end
        Col = 4'hF;

        // key 5: row R2 on column C2 only, press and gap lengths
        $display("[TB] key 5 press");
        applyStimulus(4'h5);
        pc = 0; gc = 0;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (cmdIf.pressed) pc++; else gc++;
            if (i == 20) begin
                checkOutput("key5RowC2",   {28'd0, Row},    32'hB);
                checkOutput("modelRowC2",  {28'd0, expRow}, 32'hB);
            end
            if (i == 22) checkOutput("key5RowC1", {28'd0, Row}, 32'hF);
            if (i == 24) checkOutput("key5RowC4", {28'd0, Row}, 32'hF);
            if (i == 19) Col = 4'b1011;
            if (i == 21) Col = 4'b0111;
            if (i == 23) Col = 4'b1110;
            if (cmdIf.done) break;
        end
        checkOutput("key5PressLen", pc, B + H);
        checkOutput("key5GapLen",   gc, G);
        @(negedge clk);
        checkOutput("key5ReadyBack", {31'd0, cmdIf.cmd_ready}, 32'd1);

        // sweep all keys through a rotating column scan and decode
        $display("[TB] key sweep");
        Col = 4'hF;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(4'(k));
            prevX = Col;
            found = 0;
            decoded = 4'h0;
            for (int i = 0; i < BOUND; i++) begin
                @(negedge clk);
                if (Row != 4'hF) begin
                    for (int rb = 0; rb < 4; rb++)
                        for (int cb = 0; cb < 4; cb++)
                            if (!Row[rb] && !prevX[cb]) begin
                                decoded = layout[3 - rb][3 - cb];
                                found = 1;
                            end
                end
                if (cmdIf.done) break;
                Col   = colPat[i % 4];
                prevX = Col;
            end
            checkOutput($sformatf("sweepFound%0d", k), {31'd0, found}, 32'd1);
            checkOutput($sformatf("sweepKey%0d", k),   {28'd0, decoded}, k);
            Col = 4'hF;
        end

        // cmd_valid held with key A while key 3 is pressed: ignored
        $display("[TB] busy request ignored");
        applyStimulus(4'h3);
        cmdIf.cmd_valid = 1'b1;
        cmdIf.cmd_key   = 4'hA;
        Col             = 4'b1101;
        repeat (B + 5) @(negedge clk);
        checkOutput("ignoreRowKey3", {28'd0, Row},             32'h7);
        checkOutput("ignoreReady",   {31'd0, cmdIf.cmd_ready}, 32'd0);
        waitDone("ignoreDoneTimeout");
        @(negedge clk);
        checkOutput("readyAfterDone", {31'd0, cmdIf.cmd_ready}, 32'd1);
        @(negedge clk);
        cmdIf.cmd_valid = 1'b0;
        checkOutput("acceptA", {31'd0, cmdIf.pressed}, 32'd1);
        repeat (B + 3) @(negedge clk);
        Col = 4'b1110;
        @(negedge clk);
        checkOutput("keyARow",   {28'd0, Row},    32'h7);
        checkOutput("modelKeyA", {28'd0, expRow}, 32'h7);
        waitDone("keyADoneTimeout");
        Col = 4'hF;

        // reset in the middle of a press of key 0 on column C1
        $display("[TB] reset mid-press");
        Col = 4'b0111;
        applyStimulus(4'h0);
        repeat (B + 5) @(negedge clk);
        checkOutput("key0Row", {28'd0, Row}, 32'hE);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRstRow",     {28'd0, Row},             32'hF);
        checkOutput("midRstPressed", {31'd0, cmdIf.pressed},   32'd0);
        checkOutput("midRstReady",   {31'd0, cmdIf.cmd_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (cmdIf.done) doneCnt++;
        end
        checkOutput("midRstNoDone",  doneCnt, 32'd0);
        checkOutput("midRstIdle",    {31'd0, cmdIf.cmd_ready}, 32'd1);
        Col = 4'hF;

`ifdef KEYPAD_EMU_BOUNCE_EN
        // bounce window on key 1 with C1 held low
        $display("[TB] bounce window");
        Col = 4'b0111;
        applyStimulus(4'h1);
        for (int i = 0; i < B + 10; i++) begin
            @(negedge clk);
            if (i == 4)  checkOutput("bounceBlk0",  {31'd0, Row[3]}, 32'd0);
            if (i == 14) checkOutput("bounceBlk1",  {31'd0, Row[3]}, 32'd1);
            if (i == 24) checkOutput("bounceBlk2",  {31'd0, Row[3]}, 32'd0);
            if (i == 34) checkOutput("bounceBlk3",  {31'd0, Row[3]}, 32'd1);
            if (i == 34) checkOutput("bouncePressed", {31'd0, cmdIf.pressed}, 32'd1);
            if (i == 44) checkOutput("bounceHold",  {31'd0, Row[3]}, 32'd0);
        end
        waitDone("bounceDoneTimeout");
        Col = 4'hF;
`endif

        // random commands with random column patterns and request noise
        $display("[TB] random traffic");
        for (int n = 0; n < 25; n++) begin
            applyStimulus(4'($urandom_range(0, 15)));
            for (int i = 0; i < BOUND; i++) begin
                @(negedge clk);
                if (cmdIf.done) break;
                Col             = 4'($urandom);
                cmdIf.cmd_valid = ($urandom_range(0, 3) == 0);
                cmdIf.cmd_key   = 4'($urandom);
            end
            cmdIf.cmd_valid = 1'b0;
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Behavioural/synthesizable emulator of a 4x4 matrix keypad, the passive end of the column-scan interface. It observes the active-low column lines driven by the keypad scanner and drives the active-low row lines exactly as a physical keypad would while a commanded key is held. It is used on-chip in the SOPC lab designs as a loopback stimulus source for scanner bring-up, and in benches to script key sequences.

## Interface
- HOLD_CYCLES, 10_000_000: cycles a key stays pressed (100 ms at 100 MHz); 0 is treated as 1.
- GAP_CYCLES, 5_000_000: released cycles after each press before the next command is accepted; 0 is treated as 1.
- BOUNCE_CYCLES, 200_000: length of the contact-bounce window at press start (used only with bounce compiled in).
- BOUNCE_PERIOD, 10_000: cycles between contact toggles inside the bounce window (used only with bounce compiled in).
- clk  in  1  100 MHz system clock.
- rst_n  in  1  asynchronous, active-low reset.
- Col  in  4  column lines from the scanner, active low; Col[3] = C1, Col[2] = C2, Col[1] = C3, Col[0] = C4.
- Row  out  4  row lines to the scanner, active low, registered; Row[3] = R1 through Row[0] = R4.
- cmd_valid  in  1  key-press request.
- cmd_key  in  4  hex code of the key to press (0x0-0xF).
- cmd_ready  out  1  high only in IDLE.
- pressed  out  1  high for the whole press phase, bounce window included.
- done  out  1  one-cycle pulse at the end of GAP.

## Operation
- Key map, key -> (column, row). C1: 1->R1, 4->R2, 7->R3, 0->R4. C2: 2->R1, 5->R2, 8->R3, F->R4. C3: 3->R1, 6->R2, 9->R3, E->R4. C4: A->R1, B->R2, C->R3, D->R4.
- Command accept: cmd_valid && cmd_ready. On accept, cmd_key is latched; later cmd_key changes have no effect.
- States:
  - IDLE: cmd_ready = 1. Accept -> BOUNCE with bounce compiled in, otherwise -> PRESS.
  - BOUNCE: contact starts closed and toggles every BOUNCE_PERIOD cycles. After BOUNCE_CYCLES cycles -> PRESS.
  - PRESS: contact closed for HOLD_CYCLES cycles, then -> GAP.
  - GAP: contact open for GAP_CYCLES cycles. On exit, done pulses for 1 cycle -> IDLE.
- Contact model: Row[r_key] = 0 when the contact is closed AND the key's column bit of Col is 0. Every other Row bit is 1. Col is not checked for one-hot-low: with several columns low, the key still closes its row if its own column is low.
- With Col = 4'b1111 or the contact open, Row = 4'b1111.
- Counters are 32-bit and count down from the parameter value minus 1. A 0 parameter loads 0, giving a 1-cycle phase.
- cmd_valid while cmd_ready = 0 is ignored; nothing is queued.

## Timing
- Reset values (asynchronous, immediate): Row = 4'b1111, cmd_ready = 1, pressed = 0, done = 0, state IDLE, counters 0.
- Reset mid-press releases the row in the same instant; no done pulse is produced.
- Row is registered: a Col change is reflected on Row 1 cycle later. This is well inside the scanner's 8-cycle drive-to-sample window.
- Accept at edge N: pressed = 1 and cmd_ready = 0 from N+1.
- Without bounce: contact closed for exactly HOLD_CYCLES cycles starting at N+1; pressed falls when GAP is entered.
- done is high in the last GAP cycle; cmd_ready rises the cycle after.
- Total command period: HOLD_CYCLES + GAP_CYCLES (+ BOUNCE_CYCLES) + 1 cycles, accept to next possible accept.

## Configuration
- KEYPAD_EMU_BOUNCE_EN defined: the BOUNCE state exists and the contact toggles as specified before PRESS.
- KEYPAD_EMU_BOUNCE_EN undefined: no BOUNCE state and no bounce counters. Accept goes directly to PRESS, and BOUNCE_CYCLES / BOUNCE_PERIOD are ignored.

## Test plan
- Reset release, no command, Col scanned 0111/1011/1101/1110 -> Row stays 4'b1111; cmd_ready = 1.
- HOLD_CYCLES = 100, GAP_CYCLES = 50, cmd_key = 0x5 -> Row = 4'b1011 one cycle after Col = 4'b1011, 1111 for the other columns. pressed high for 100 cycles, done pulses after 50 more, cmd_ready returns. Also connected to the scanner: the scanner's key output reads 5.
- Sweep all 16 keys through the scanner -> decoded key equals cmd_key for each; release flag drops during GAP.
- cmd_valid held high during PRESS with cmd_key = 0xA -> ignored. After done, a new accept presses A: Row = 4'b0111 when Col = 4'b1110.
- Assert rst_n low mid-PRESS for key 0x0 with Col = 4'b0111 -> Row = 4'b1111 immediately, no done, IDLE after release.
- KEYPAD_EMU_BOUNCE_EN, BOUNCE_CYCLES = 40, BOUNCE_PERIOD = 10, key 0x1, Col held 4'b0111 -> Row[3] reads 0,1,0,1 in 10-cycle blocks, then 0 for HOLD_CYCLES; pressed high throughout.
